// File: rtl/ps2_pkg.sv
// Shared PS/2 frame constants, byte-0 flag layout, state types and the axis clamp helper
// used by the mouse tracker and its receiver.
package ps2_pkg;

   localparam int FRAME_LEN = 11;
   localparam int DATA_BITS = 8;

   localparam int FLAG_L    = 0;
   localparam int FLAG_R    = 1;
   localparam int FLAG_M    = 2;
   localparam int FLAG_SYNC = 3;
   localparam int FLAG_XS   = 4;
   localparam int FLAG_YS   = 5;
   localparam int FLAG_XO   = 6;
   localparam int FLAG_YO   = 7;

   typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
   typedef enum logic [1:0] {PK_B0, PK_B1, PK_B2, PK_UPDATE} pkt_state_e;

   typedef struct packed {
      logic       y_ovf;
      logic       x_ovf;
      logic       y_sign;
      logic       x_sign;
      logic [2:0] btn;
   } pkt_flags_t;

   function automatic logic [9:0] clamp_axis(input logic signed [10:0] v, input logic [9:0] lim);
      if (v < 0) return '0;
      if (v > $signed({1'b0, lim})) return lim;
      return v[9:0];
   endfunction

endpackage

// File: rtl/ps2_mouse_tracker_if.sv
// PS/2 line inputs and cursor/button outputs of the mouse tracker.
interface ps2_mouse_tracker_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [9:0] mouse_x;
   logic [9:0] mouse_y;
   logic [2:0] btn;
   logic       pkt_valid;

   modport master (output ps2_clk, ps2_data, input mouse_x, mouse_y, btn, pkt_valid);
   modport slave  (input ps2_clk, ps2_data, output mouse_x, mouse_y, btn, pkt_valid);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 receive front end: synchronisers, ps2_clk glitch filter, frame FSM and frame watchdog.
// Parity is enforced only when PS2_PARITY_CHECK_EN is defined.
//
// state     | meaning
// RX_IDLE   | waiting for a start bit (strobe with data low)
// RX_DATA   | shifting in 8 data bits, LSB first
// RX_PARITY | sampling the parity bit
// RX_STOP   | checking the stop bit; emits byte_done_o or byte_err_o
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic [7:0] data_o,
   output logic       byte_done_o,
   output logic       byte_err_o
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CW = $clog2(FRAME_LEN);

   logic [1:0]    clk_sync_q, data_sync_q;
   logic          filt_q, strobe_q;
   logic [FW-1:0] filt_cnt_q;
   rx_state_e     state_q, state_d;
   logic [CW-1:0] bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [TW-1:0] wd_q, wd_d;
   logic          din, parity_ok;

   assign din    = data_sync_q[1];
   assign data_o = shift_q;

`ifdef PS2_PARITY_CHECK_EN
   logic par_q, par_d;
   assign parity_ok = ^{shift_q, par_q};
`else
   assign parity_ok = 1'b1;
`endif

   // The filter counts down while the synced level disagrees; a full run of agreeing samples flips it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         filt_q      <= 1'b1;
         filt_cnt_q  <= FW'(FILTER_LEN - 1);
         strobe_q    <= 1'b0;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
         data_sync_q <= {data_sync_q[0], ps2_data_i};
         strobe_q    <= 1'b0;
         if (clk_sync_q[1] == filt_q) begin
            filt_cnt_q <= FW'(FILTER_LEN - 1);
         end else if (filt_cnt_q == '0) begin
            filt_q     <= clk_sync_q[1];
            filt_cnt_q <= FW'(FILTER_LEN - 1);
            strobe_q   <= filt_q;
         end else begin
            filt_cnt_q <= filt_cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RX_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         wd_q      <= TW'(TIMEOUT_CYCLES - 1);
`ifdef PS2_PARITY_CHECK_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         wd_q      <= wd_d;
`ifdef PS2_PARITY_CHECK_EN
         par_q     <= par_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      wd_d        = wd_q;
      byte_done_o = 1'b0;
      byte_err_o  = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_d       = par_q;
`endif
      if (state_q == RX_IDLE || strobe_q) begin
         wd_d = TW'(TIMEOUT_CYCLES - 1);
      end else if (wd_q == '0) begin
         state_d = RX_IDLE;
      end else begin
         wd_d = wd_q - 1'b1;
      end

      if (strobe_q) begin
         case (state_q)
            RX_IDLE: begin
               if (!din) begin
                  state_d   = RX_DATA;
                  bit_cnt_d = '0;
               end
            end
            RX_DATA: begin
               shift_d = {din, shift_q[7:1]};
               if (bit_cnt_q == CW'(DATA_BITS - 1)) state_d = RX_PARITY;
               else bit_cnt_d = bit_cnt_q + 1'b1;
            end
            RX_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
               par_d = din;
`endif
               state_d = RX_STOP;
            end
            RX_STOP: begin
               if (din && parity_ok) byte_done_o = 1'b1;
               else byte_err_o = 1'b1;
               state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse tracker: assembles 3-byte movement packets and keeps a screen-clamped cursor
// position plus button state. Define PS2_PARITY_CHECK_EN to drop bytes with bad parity.
//
// state     | meaning
// PK_B0     | waiting for a flags byte with bit3 set
// PK_B1     | waiting for the X delta byte
// PK_B2     | waiting for the Y delta byte
// PK_UPDATE | apply deltas, clamp, pulse pkt_valid
module ps2_mouse_tracker
   import ps2_pkg::*;
#(
   parameter int X_MAX          = 639,
   parameter int Y_MAX          = 479,
   parameter int X_INIT         = 320,
   parameter int Y_INIT         = 240,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input logic                clk,
   input logic                reset,
   ps2_mouse_tracker_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [7:0]        rx_data;
   logic              rx_done, rx_err;
   pkt_state_e        pstate_q, pstate_d;
   pkt_flags_t        flags_q, flags_d;
   logic [7:0]        xb_q, xb_d, yb_q, yb_d;
   logic [TW-1:0]     pwd_q, pwd_d;
   logic [9:0]        mouse_x_q, mouse_x_d, mouse_y_q, mouse_y_d;
   logic [2:0]        btn_q, btn_d;
   logic              pkt_valid_q, pkt_valid_d;
   logic signed [8:0] dx, dy;
   logic signed [10:0] nx, ny;

   ps2_rx #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx (
      .clk         (clk),
      .rst_n       (reset),
      .ps2_clk_i   (bus.ps2_clk),
      .ps2_data_i  (bus.ps2_data),
      .data_o      (rx_data),
      .byte_done_o (rx_done),
      .byte_err_o  (rx_err)
   );

   // PS/2 +y is up, screen rows grow downward, hence the subtraction on y.
   assign dx = {flags_q.x_sign, xb_q};
   assign dy = {flags_q.y_sign, yb_q};
   assign nx = $signed({1'b0, mouse_x_q}) + {{2{dx[8]}}, dx};
   assign ny = $signed({1'b0, mouse_y_q}) - {{2{dy[8]}}, dy};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pstate_q    <= PK_B0;
         flags_q     <= '0;
         xb_q        <= '0;
         yb_q        <= '0;
         pwd_q       <= TW'(TIMEOUT_CYCLES - 1);
         mouse_x_q   <= 10'(X_INIT);
         mouse_y_q   <= 10'(Y_INIT);
         btn_q       <= '0;
         pkt_valid_q <= 1'b0;
      end else begin
         pstate_q    <= pstate_d;
         flags_q     <= flags_d;
         xb_q        <= xb_d;
         yb_q        <= yb_d;
         pwd_q       <= pwd_d;
         mouse_x_q   <= mouse_x_d;
         mouse_y_q   <= mouse_y_d;
         btn_q       <= btn_d;
         pkt_valid_q <= pkt_valid_d;
      end
   end

   always_comb begin
      pstate_d    = pstate_q;
      flags_d     = flags_q;
      xb_d        = xb_q;
      yb_d        = yb_q;
      pwd_d       = pwd_q;
      mouse_x_d   = mouse_x_q;
      mouse_y_d   = mouse_y_q;
      btn_d       = btn_q;
      pkt_valid_d = 1'b0;

      if (pstate_q != PK_B1 && pstate_q != PK_B2 || rx_done || rx_err) begin
         pwd_d = TW'(TIMEOUT_CYCLES - 1);
      end else if (pwd_q == '0) begin
         pstate_d = PK_B0;
      end else begin
         pwd_d = pwd_q - 1'b1;
      end

      case (pstate_q)
         PK_B0: begin
            if (rx_done && rx_data[FLAG_SYNC]) begin
               flags_d.y_ovf  = rx_data[FLAG_YO];
               flags_d.x_ovf  = rx_data[FLAG_XO];
               flags_d.y_sign = rx_data[FLAG_YS];
               flags_d.x_sign = rx_data[FLAG_XS];
               flags_d.btn    = {rx_data[FLAG_M], rx_data[FLAG_R], rx_data[FLAG_L]};
               pstate_d       = PK_B1;
            end
         end
         PK_B1: begin
            if (rx_done) begin
               xb_d     = rx_data;
               pstate_d = PK_B2;
            end else if (rx_err) begin
               pstate_d = PK_B0;
            end
         end
         PK_B2: begin
            if (rx_done) begin
               yb_d     = rx_data;
               pstate_d = PK_UPDATE;
            end else if (rx_err) begin
               pstate_d = PK_B0;
            end
         end
         PK_UPDATE: begin
            if (!flags_q.x_ovf) mouse_x_d = clamp_axis(nx, 10'(X_MAX));
            if (!flags_q.y_ovf) mouse_y_d = clamp_axis(ny, 10'(Y_MAX));
            btn_d       = flags_q.btn;
            pkt_valid_d = 1'b1;
            pstate_d    = PK_B0;
         end
         default: pstate_d = PK_B0;
      endcase
   end

   assign bus.mouse_x   = mouse_x_q;
   assign bus.mouse_y   = mouse_y_q;
   assign bus.btn       = btn_q;
   assign bus.pkt_valid = pkt_valid_q;

endmodule

// File: doc/ps2_mouse_tracker.md
Name: ps2_mouse_tracker

Overview:
Receive-side PS/2 mouse front end that produces the mouse_x/mouse_y cursor position consumed by the display/graphics path. It does the following:
- Samples the device-driven PS/2 clock/data lines.
- Deserialises 11-bit frames and assembles standard 3-byte movement packets.
- Accumulates signed deltas into a screen-clamped absolute position, plus button state.
The mouse is assumed to be streaming; host-to-device transmission is out of scope.

Parameters:
X_MAX, 639, largest legal mouse_x
Y_MAX, 479, largest legal mouse_y
X_INIT, 320, mouse_x after reset
Y_INIT, 240, mouse_y after reset
FILTER_LEN, 8, consecutive equal samples needed to accept a ps2_clk level change
TIMEOUT_CYCLES, 100000, idle clk cycles inside a frame or packet before abort

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
ps2_clk  in  1  PS/2 clock from mouse, asynchronous
ps2_data  in  1  PS/2 data from mouse, asynchronous
mouse_x  out  10  cursor column, 0..X_MAX
mouse_y  out  10  cursor row, 0..Y_MAX (0 = top)
btn  out  3  {middle, right, left}, 1 = pressed
pkt_valid  out  1  one-cycle pulse when a packet updates the outputs

Behaviour:
- Reset values: mouse_x=X_INIT, mouse_y=Y_INIT, btn=0, pkt_valid=0. All FSMs go to their first state, counters clear.
- Reset asserted mid-frame or mid-packet discards the partial data.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchroniser.
  - Filtered ps2_clk changes level only after FILTER_LEN identical synchronised samples.
  - A falling edge of the filtered clock is one "bit strobe".
- Frame receiver FSM:
  - IDLE: a strobe with data=0 is the start bit → DATA. A strobe with data=1 is ignored.
  - DATA: 8 strobes, LSB first, into a shift register → PARITY.
  - PARITY: capture bit; odd parity expected → STOP.
  - STOP: data=1 → byte_done for one cycle; data=0 → framing error, byte dropped. Both → IDLE.
  - Watchdog: counts clk cycles since the last strobe while not in IDLE. Reaching TIMEOUT_CYCLES → IDLE, partial byte discarded.
- Packet FSM:
  - B0: accept byte only if bit3=1, else discard (resync). Latch flags → B1.
  - B1: latch X byte → B2.
  - B2: latch Y byte → UPDATE.
  - UPDATE: one cycle; apply the update → B0.
  - Packet watchdog: TIMEOUT_CYCLES with no byte while in B1/B2 → B0.
  - Any dropped byte (parity or framing error) while in B1/B2 → B0.
- Byte-0 flags: bit0 L, bit1 R, bit2 M, bit4 X sign, bit5 Y sign, bit6 X overflow, bit7 Y overflow.
- Arithmetic (UPDATE cycle):
  - dx = signed 9-bit {xsign, xbyte}; dy likewise.
  - nx = mouse_x + dx, in 11-bit signed.
  - ny = mouse_y − dy, in 11-bit signed (PS/2 +y is up, screen +y is down).
  - Clamp: result <0 → 0; result >MAX → MAX; otherwise the result.
  - Overflow bit set for an axis → that axis is unchanged. Buttons still update.
- Latency: the outputs and the pkt_valid pulse take effect on the clock edge ending the UPDATE cycle. That is 2 clk cycles after the third byte's stop-bit strobe.
- Outputs are registered and held between packets.

Optional Feature:
PS2_PARITY_CHECK_EN
- Defined: parity mismatch drops the byte, which counts as a dropped byte for packet resync.
- Undefined: the parity bit is sampled but ignored. Only start/stop bits and bit3 validate data.

Decomposition:
- Shared package ps2_pkg holds:
  - PS/2 frame constants: frame length 11, data bits 8.
  - Byte-0 flag bit indices.
  - Receiver state typedef: IDLE/DATA/PARITY/STOP.
  - Packet state typedef: B0/B1/B2/UPDATE.
- Sub-module ps2_rx: synchronisers, glitch filter, frame FSM, frame watchdog. Output is data[7:0] plus a byte_done pulse.
- Top level: packet FSM, accumulate/clamp, outputs.

Test Plan:
1. Reset, then packet 0x08,0x0A,0x05 → mouse_x=330, mouse_y=235, btn=0, single pkt_valid pulse.
2. From 330,235, packet 0x39,0x80,0xF0 (dx=−128, dy=−16, left) → mouse_x=202, mouse_y=251, btn=3'b001.
3. From x=5, dx=−20 → mouse_x=0. From y=470, dy=−50 → mouse_y=479 (clamping).
4. Stray byte 0x00 with bit3=0, then a valid packet → stray ignored, valid packet applied once.
5. Two bytes of a packet, then silence >TIMEOUT_CYCLES, then a full packet → only the full packet applied.
6. Flipped parity bit in byte 1 → with PS2_PARITY_CHECK_EN: no update and resync. Without: update applied. Plus a 2-cycle ps2_clk glitch → ignored.
